// File: rtl/ysyx_22050535_regfile_mp.sv
// Multi-port integer register file with per-register busy scoreboard for the pipelined NPC.
// Define YSYX_22050535_REGS_BYPASS_EN to forward same-cycle write data onto the read ports.

module ysyx_22050535_regfile_rdport #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_REGS   = 1 << ADDR_WIDTH
) (
    input  logic [ADDR_WIDTH-1:0]                raddr_i,
    input  logic [NUM_REGS-1:0][DATA_WIDTH-1:0]  regs_i,
    input  logic [NUM_REGS-1:0]                  busy_i,
    input  logic                                 byp_vld_i,
    input  logic [DATA_WIDTH-1:0]                byp_data_i,
    output logic [DATA_WIDTH-1:0]                rdata_o,
    output logic                                 rbusy_o
);
    always_comb begin
        rdata_o = regs_i[raddr_i];
        rbusy_o = busy_i[raddr_i];
        if (byp_vld_i) begin
            rdata_o = byp_data_i;
            rbusy_o = 1'b0;
        end
        if (raddr_i == '0) begin
            rdata_o = '0;
            rbusy_o = 1'b0;
        end
    end
endmodule

module ysyx_22050535_regfile_mp #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_RD     = 2,
    parameter int NUM_WR     = 2,
    parameter int CNT_WIDTH  = ADDR_WIDTH + 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_WR-1:0]            wen,
    input  logic [NUM_WR*ADDR_WIDTH-1:0] waddr,
    input  logic [NUM_WR*DATA_WIDTH-1:0] wdata,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] raddr,
    output logic [NUM_RD*DATA_WIDTH-1:0] rdata,
    output logic [NUM_RD-1:0]            rbusy,
    input  logic                         issue_valid,
    input  logic [ADDR_WIDTH-1:0]        issue_addr,
    output logic [CNT_WIDTH-1:0]         busy_cnt
);
    localparam int NUM_REGS = 1 << ADDR_WIDTH;

    logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_q, regs_d;
    logic [NUM_REGS-1:0]                 busy_q, busy_d;
    logic [CNT_WIDTH-1:0]                busy_cnt_q, busy_cnt_d;

    // Ascending port order makes the highest-indexed port win on a shared index;
    // the issue set is applied last so a newer producer outranks a writeback.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        for (int k = 0; k < NUM_WR; k++) begin
            if (wen[k] && (waddr[k*ADDR_WIDTH +: ADDR_WIDTH] != '0)) begin
                regs_d[waddr[k*ADDR_WIDTH +: ADDR_WIDTH]] = wdata[k*DATA_WIDTH +: DATA_WIDTH];
                busy_d[waddr[k*ADDR_WIDTH +: ADDR_WIDTH]] = 1'b0;
            end
        end
        if (issue_valid && (issue_addr != '0))
            busy_d[issue_addr] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_comb begin
        busy_cnt_d = '0;
        for (int r = 0; r < NUM_REGS; r++)
            busy_cnt_d = busy_cnt_d + CNT_WIDTH'(busy_d[r]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q     <= '0;
            busy_q     <= '0;
            busy_cnt_q <= '0;
        end else begin
            regs_q     <= regs_d;
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    assign busy_cnt = busy_cnt_q;

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic                  byp_vld;
        logic [DATA_WIDTH-1:0] byp_data;

`ifdef YSYX_22050535_REGS_BYPASS_EN
        // Bypass is gated by reset so a held reset still reads all zeros.
        always_comb begin
            byp_vld  = 1'b0;
            byp_data = '0;
            for (int k = 0; k < NUM_WR; k++) begin
                if (rst_n && wen[k] &&
                    (waddr[k*ADDR_WIDTH +: ADDR_WIDTH] == raddr[i*ADDR_WIDTH +: ADDR_WIDTH])) begin
                    byp_vld  = 1'b1;
                    byp_data = wdata[k*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
`else
        assign byp_vld  = 1'b0;
        assign byp_data = '0;
`endif

        ysyx_22050535_regfile_rdport #(
            .DATA_WIDTH (DATA_WIDTH),
            .ADDR_WIDTH (ADDR_WIDTH),
            .NUM_REGS   (NUM_REGS)
        ) u_rdport (
            .raddr_i    (raddr[i*ADDR_WIDTH +: ADDR_WIDTH]),
            .regs_i     (regs_q),
            .busy_i     (busy_q),
            .byp_vld_i  (byp_vld),
            .byp_data_i (byp_data),
            .rdata_o    (rdata[i*DATA_WIDTH +: DATA_WIDTH]),
            .rbusy_o    (rbusy[i])
        );
    end
endmodule

// File: doc/ysyx_22050535_regfile_mp.md
# ysyx_22050535_regfile_mp

Parametrised multi-port integer register file with a per-register busy scoreboard, successor to the single-write/dual-read register file used by the single-cycle core. Serves the decode/writeback stages of the pipelined NPC: N combinational read ports, M synchronous write ports with fixed priority, register 0 hardwired to zero, and a busy bit per register set at issue and cleared at writeback so decode can detect RAW hazards. Optional same-cycle write-to-read bypass.

## Interface
- DATA_WIDTH, 64, register width in bits
- ADDR_WIDTH, 5, register index width; NUM_REGS = 2^ADDR_WIDTH
- NUM_RD, 2, read ports (1..4)
- NUM_WR, 2, write ports (1..2)
- CNT_WIDTH, ADDR_WIDTH+1, width of busy_cnt
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- wen  in  NUM_WR  per-port write enable
- waddr  in  NUM_WR*ADDR_WIDTH  write indices, port k at bits [k*ADDR_WIDTH +: ADDR_WIDTH]
- wdata  in  NUM_WR*DATA_WIDTH  write data, same packing
- raddr  in  NUM_RD*ADDR_WIDTH  read indices, same packing
- rdata  out  NUM_RD*DATA_WIDTH  read data, combinational
- rbusy  out  NUM_RD  busy flag of the register addressed by each read port
- issue_valid  in  1  mark issue_addr as having a pending producer
- issue_addr  in  ADDR_WIDTH  destination of the issuing instruction
- busy_cnt  out  CNT_WIDTH  registered count of busy registers

## Operation
- Storage: NUM_REGS x DATA_WIDTH array plus NUM_REGS busy bits.
- Reset (rst_n low, asynchronous): all registers 0, all busy bits 0, busy_cnt 0; rdata reads 0, rbusy 0 while held.
- Write: on clk, for each k with wen[k]=1 and waddr[k]!=0, regs[waddr[k]] <= wdata[k]. Two ports to same index: higher port index wins. Writes to index 0 ignored.
- Busy clear: any wen[k]=1 with waddr[k]!=0 clears busy[waddr[k]] on clk.
- Busy set: issue_valid=1 and issue_addr!=0 sets busy[issue_addr] on clk. Set and clear on same index in same cycle: set wins (newer producer).
- Read: rdata[i] = 0 if raddr[i]==0, else regs[raddr[i]] (or bypass value, see Configuration). rbusy[i] = 0 for index 0.
- busy_cnt: popcount of the next-state busy vector, registered; always equals popcount of current busy bits. Max value NUM_REGS-1.
- Register 0 is never busy, never written; reads always 0.

## Timing
- Read latency 0 (combinational from raddr and state).
- Write latency 1: data visible on rdata the cycle after the write edge (without bypass).
- Busy set/clear visible on rbusy and busy_cnt the cycle after the edge.
- Reset asserted mid-write: reset dominates; no write committed. Release synchronous to clk by the system; first write accepted on the first edge after release.
- No handshake/backpressure: every enabled write and issue is accepted every cycle.

## Configuration
- YSYX_22050535_REGS_BYPASS_EN defined: if raddr[i]!=0 matches any enabled write port this cycle, rdata[i] = that port's wdata (highest matching port) and rbusy[i] = 0 (same-cycle issue not considered). Adds combinational path wdata -> rdata.
- Not defined: rdata/rbusy reflect stored state only; same-cycle writes seen next cycle.

## Test plan
- Reset: hold rst_n=0 after random writes -> all rdata 0, rbusy 0, busy_cnt 0; release, read x1..x31 -> 0.
- Basic write/read: wen[0]=1, waddr=5, wdata=0xDEADBEEF_00000001; next cycle raddr[0]=5 -> 0xDEADBEEF_00000001; write x0=0x1234 -> raddr=0 reads 0.
- Port conflict: wen=2'b11, both waddr=7, wdata0=0x11, wdata1=0x22 -> x7 reads 0x22 next cycle.
- Scoreboard: issue x3, x4 on consecutive cycles -> busy_cnt 1 then 2, rbusy for x3=1; write x3 -> busy_cnt 1; same-cycle issue x4 + write x4 -> x4 remains busy, busy_cnt stays 1.
- Bypass: write x9=0xABCD with raddr[1]=9 same cycle -> with YSYX_22050535_REGS_BYPASS_EN rdata=0xABCD, rbusy=0; without it rdata=old value, 0xABCD next cycle.
- Async reset mid-operation: assert rst_n low between edges while wen=1 -> outputs zero immediately, write not committed after release.
